// File: rtl/dll_pkg.sv
// Data-link-layer shared types: framed TLP layout, sequence helpers, replay states.
// Pure declarations; no latency or flow control of its own.
package dll_pkg;

  localparam int SEQ_W   = 12;
  localparam int SEQ_MSB = 123;
  localparam int SEQ_LSB = 112;
  localparam int TLP_W   = 96;
  localparam int LCRC_W  = 16;

  typedef struct packed {
    logic [3:0]        rsvd;
    logic [SEQ_W-1:0]  seq;
    logic [TLP_W-1:0]  payload;
    logic [LCRC_W-1:0] lcrc;
  } tlp_t;

  typedef enum logic {
    TX_NORMAL,
    TX_REPLAY
  } tx_state_t;

  // Forward distance from from_seq to to_seq in the 12-bit sequence space.
  function automatic logic [SEQ_W-1:0] seq_dist(input logic [SEQ_W-1:0] from_seq,
                                                input logic [SEQ_W-1:0] to_seq);
    return to_seq - from_seq;
  endfunction

endpackage

// File: rtl/replay_buffer_if.sv
// Replay buffer bus: TLP in (valid/ready), TLP out (valid/ready), ACK/NAK DLLP and status.
// Wires only; the master modport drives TLPs and DLLPs, the slave modport is the buffer.
interface replay_buffer_if
  import dll_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              dllp_valid;
  logic              dllp_nak;
  logic [SEQ_W-1:0]  dllp_seq;
  logic              replay_active;
  logic              retrain;
  logic [ADDR_W:0]   count;

  modport master (
    output in_valid, in_data, out_ready, dllp_valid, dllp_nak, dllp_seq,
    input  in_ready, out_valid, out_data, replay_active, retrain, count
  );

  modport slave (
    input  in_valid, in_data, out_ready, dllp_valid, dllp_nak, dllp_seq,
    output in_ready, out_valid, out_data, replay_active, retrain, count
  );
endinterface

// File: rtl/replay_buffer_timer.sv
// Replay timer plus replay_num; expire is combinational, retrain pulses the cycle after the 4th trigger.
// No flow control: clear/enable come from the buffer every cycle.
module replay_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic trig,
  input  logic purge,
  output logic expire,
  output logic retrain
);
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] tmr;
  logic [1:0]    replay_num;

  assign expire = en && (tmr == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      tmr <= '0;
    else if (clr) tmr <= '0;
    else if (en)  tmr <= tmr + TW'(1);
  end

  // A purging NAK resets the attempt count before its own replay is counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      replay_num <= '0;
      retrain    <= 1'b0;
    end else begin
      retrain <= 1'b0;
      if (trig) begin
        if (!purge && replay_num == 2'd3) begin
          replay_num <= '0;
          retrain    <= 1'b1;
        end else begin
          replay_num <= (purge ? 2'd0 : replay_num) + 2'd1;
        end
      end else if (purge) begin
        replay_num <= '0;
      end
    end
  end
endmodule

// File: rtl/replay_buffer.sv
// Retains transmitted TLPs until ACKed; replays from oldest on NAK/timeout. out_data is a
// combinational read of mem[rd]; in_ready drops when DEPTH entries are unacknowledged.
module replay_buffer
  import dll_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 1024
) (
  input logic            clk,
  input logic            rst,
  replay_buffer_if.slave bus
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   head, rd, tail, replay_end;
  logic [ADDR_W:0]   cnt, n_eff, head_n, rd_adv, rd_n, remain;
  logic [SEQ_W-1:0]  head_seq, n;
  logic              wr, tx, purge, nak_trig, expire, trigger, replay_done, retrain;
  tx_state_t         state, state_n;

  assign cnt      = tail - head;
  assign wr       = bus.in_valid && bus.in_ready;
  assign tx       = bus.out_valid && bus.out_ready;
  assign head_seq = mem[head[ADDR_W-1:0]][SEQ_MSB:SEQ_LSB];
  assign n        = seq_dist(head_seq, bus.dllp_seq) + SEQ_W'(1);

  // n == 0 means the DLLP acknowledges a TLP already purged.
  assign purge    = bus.dllp_valid && (cnt != '0) && (n != '0) && (n <= SEQ_W'(cnt));
  assign n_eff    = purge ? n[ADDR_W:0] : '0;
  assign head_n   = head + n_eff;
  assign remain   = cnt - n_eff;
  assign nak_trig = bus.dllp_valid && bus.dllp_nak && (remain != '0);
  assign trigger  = nak_trig || (expire && !purge);
  assign rd_adv   = rd + (ADDR_W+1)'(tx);

  always_comb begin
    rd_n = rd_adv;
    if (trigger || (purge && ((rd_adv - head) < n_eff))) rd_n = head_n;
  end

  // An ACK may purge past the replay end mark, which also finishes the replay.
  assign replay_done = (rd_n == replay_end) || (purge && ((replay_end - head) <= n_eff));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TX_NORMAL;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      TX_NORMAL: if (trigger) state_n = TX_REPLAY;
      TX_REPLAY: if (!trigger && replay_done) state_n = TX_NORMAL;
      default:   state_n = TX_NORMAL;
    endcase
  end

  always_comb begin
    bus.replay_active = (state == TX_REPLAY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      rd         <= '0;
      tail       <= '0;
      replay_end <= '0;
    end else begin
      head <= head_n;
      rd   <= rd_n;
      tail <= tail + (ADDR_W+1)'(wr);
      if (trigger) replay_end <= tail;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[tail[ADDR_W-1:0]] <= bus.in_data;
  end

  replay_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    ((cnt == '0) || purge || trigger),
    .en     ((cnt != '0) && (state == TX_NORMAL)),
    .trig   (trigger),
    .purge  (purge),
    .expire (expire),
    .retrain(retrain)
  );

  assign bus.in_ready  = cnt < (ADDR_W+1)'(DEPTH);
  assign bus.out_valid = (rd != tail);
  assign bus.out_data  = mem[rd[ADDR_W-1:0]];
  assign bus.count     = cnt;
  assign bus.retrain   = retrain;
endmodule

// File: tb/tb_replay_buffer.sv
// Directed and random stimulus for replay_buffer against a queue-based retransmit model.
module tb_replay_buffer;
  import dll_pkg::*;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int TO     = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  replay_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  replay_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: q holds unacknowledged TLPs oldest first; sent = how many of them went out
  // since the last replay start; rend = how many the current replay must resend.
  logic [127:0] q[$];
  int           sent, rend, timer, rnum;
  bit           ract, rtr_exp;
  logic [11:0]  next_seq;

  logic [11:0]  tx_log[$];
  int           ract_tx, rstarts, rtr_seen, rtr_at;
  bit           prev_ract;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [11:0] s);
    tlp_t t;
    t.rsvd    = 4'b0;
    t.seq     = s;
    t.payload = {$urandom, $urandom, $urandom};
    t.lcrc    = 16'($urandom);
    return t;
  endfunction

  task automatic model_reset();
    q.delete();
    sent = 0; rend = 0; timer = 0; rnum = 0;
    ract = 1'b0; rtr_exp = 1'b0; prev_ract = 1'b0;
  endtask

  task automatic model_update();
    int cnt, n, remain;
    bit tx, wr, purge, expire, nakt, trig;
    cnt   = q.size();
    n     = 0;
    purge = 1'b0;
    tx    = bus.out_ready && (sent < cnt);
    wr    = bus.in_valid && (cnt < DEPTH);
    if (bus.dllp_valid && cnt > 0) begin
      n = (int'(bus.dllp_seq) - int'(q[0][SEQ_MSB:SEQ_LSB]) + 1 + 4096) % 4096;
      purge = (n >= 1) && (n <= cnt);
    end
    if (!purge) n = 0;
    expire = (cnt > 0) && !ract && (timer == TO - 1);
    remain = cnt - n;
    nakt   = bus.dllp_valid && bus.dllp_nak && (remain > 0);
    trig   = nakt || (expire && !purge);

    if (cnt == 0 || purge || trig) timer = 0;
    else if (!ract) timer++;

    rtr_exp = 1'b0;
    if (trig) begin
      if (!purge && rnum == 3) begin
        rnum = 0;
        rtr_exp = 1'b1;
      end else begin
        rnum = (purge ? 0 : rnum) + 1;
      end
    end else if (purge) begin
      rnum = 0;
    end

    sent += int'(tx);
    for (int k = 0; k < n; k++) void'(q.pop_front());
    sent = (sent > n) ? sent - n : 0;
    rend -= n;
    if (trig) begin
      sent = 0;
      ract = 1'b1;
      rend = remain;
    end else if (ract && sent >= rend) begin
      ract = 1'b0;
    end
    if (wr) begin
      q.push_back(bus.in_data);
      next_seq++;
    end
  endtask

  task automatic step();
    chk("count", 128'(bus.count), 128'(q.size()));
    chk("in_ready", 128'(bus.in_ready), 128'(q.size() < DEPTH));
    chk("out_valid", 128'(bus.out_valid), 128'(sent < q.size()));
    if (sent < q.size()) chk("out_data", bus.out_data, q[sent]);
    chk("replay_active", 128'(bus.replay_active), 128'(ract));
    chk("retrain", 128'(bus.retrain), 128'(rtr_exp));
    if (bus.out_valid && bus.out_ready) tx_log.push_back(bus.out_data[SEQ_MSB:SEQ_LSB]);
    if (bus.out_valid && bus.out_ready && bus.replay_active) ract_tx++;
    if (bus.replay_active && !prev_ract) rstarts++;
    prev_ract = bus.replay_active;
    if (bus.retrain) begin
      rtr_seen++;
      rtr_at = rstarts;
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input bit ordy, input bit dv = 1'b0,
                       input bit nak = 1'b0, input logic [11:0] ds = 12'd0);
    bus.in_valid   = iv;
    bus.in_data    = mk(next_seq);
    bus.out_ready  = ordy;
    bus.dllp_valid = dv;
    bus.dllp_nak   = nak;
    bus.dllp_seq   = ds;
    step();
  endtask

  task automatic do_reset();
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.dllp_valid = 1'b0;
    bus.dllp_nak   = 1'b0;
    bus.dllp_seq   = '0;
    rst = 1'b1;
    #2;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
    chk("rst_count", 128'(bus.count), 128'(0));
    chk("rst_replay_active", 128'(bus.replay_active), 128'(1'b0));
    chk("rst_retrain", 128'(bus.retrain), 128'(1'b0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] ds;
    bus.in_data = '0;
    next_seq = '0;
    tx_log.delete();
    ract_tx = 0; rstarts = 0; rtr_seen = 0; rtr_at = 0;
    do_reset();

    // In-order transmit, then cumulative ACK
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    chk("t1_tx_len", 128'(tx_log.size()), 128'(4));
    for (int i = 0; i < 4 && i < tx_log.size(); i++) chk("t1_tx_seq", 128'(tx_log[i]), 128'(i));
    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'd1);
    chk("t1_count_after_ack1", 128'(bus.count), 128'(2));
    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'd2);
    chk("t1_head_seq_was_2", 128'(bus.count), 128'(1));

    // Fill to DEPTH with the link stalled
    do_reset();
    next_seq = '0;
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0);
    chk("t2_full_in_ready", 128'(bus.in_ready), 128'(1'b0));
    chk("t2_full_count", 128'(bus.count), 128'(16));
    drive(1'b1, 1'b0);
    chk("t2_17th_ignored", 128'(bus.count), 128'(16));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 12'd15);
    chk("t2_ack_all_count", 128'(bus.count), 128'(0));
    chk("t2_ack_all_ready", 128'(bus.in_ready), 128'(1'b1));

    // NAK purges then replays the rest
    do_reset();
    next_seq = '0;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    tx_log.delete();
    ract_tx = 0;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 12'd1);
    chk("t3_count", 128'(bus.count), 128'(3));
    chk("t3_replay_active", 128'(bus.replay_active), 128'(1'b1));
    chk("t3_first_replay_seq", 128'(bus.out_data[SEQ_MSB:SEQ_LSB]), 128'(2));
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
    chk("t3_tx_len", 128'(tx_log.size()), 128'(3));
    for (int i = 0; i < 3 && i < tx_log.size(); i++) chk("t3_tx_seq", 128'(tx_log[i]), 128'(i + 2));
    chk("t3_replay_transfers", 128'(ract_tx), 128'(3));
    chk("t3_replay_done", 128'(bus.replay_active), 128'(1'b0));

    // Timer replays; fourth consecutive one requests retrain
    do_reset();
    next_seq = '0;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    rstarts = 0; rtr_seen = 0; rtr_at = 0;
    for (int i = 0; i < 8 * TO && rstarts < 4; i++) drive(1'b0, 1'b1);
    chk("t4_replays", 128'(rstarts), 128'(4));
    chk("t4_retrain_once", 128'(rtr_seen), 128'(1));
    chk("t4_retrain_on_4th", 128'(rtr_at), 128'(4));
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'd0);
    chk("t4_ack_count", 128'(bus.count), 128'(1));
    rstarts = 0;
    for (int i = 0; i < 6 * TO && rstarts < 3; i++) drive(1'b0, 1'b1);
    chk("t4_post_ack_replays", 128'(rstarts), 128'(3));
    chk("t4_no_retrain_after_ack", 128'(rtr_seen), 128'(1));

    // Sequence-number wrap and a stale ACK
    do_reset();
    next_seq = 12'd4094;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'd0);
    chk("t5_wrap_ack", 128'(bus.count), 128'(1));
    drive(1'b0, 1'b1, 1'b1, 1'b0, 12'd4000);
    chk("t5_stale_ack", 128'(bus.count), 128'(1));

    // Random traffic
    do_reset();
    next_seq = 12'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if (q.size() > 0)
        ds = q[0][SEQ_MSB:SEQ_LSB] - 12'd2 + 12'($urandom_range(0, q.size() + 3));
      else
        ds = 12'($urandom);
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, ds);
    end

    // Reset in the middle of a replay
    do_reset();
    next_seq = '0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF);
    chk("t7_replay_started", 128'(bus.replay_active), 128'(1'b1));
    drive(1'b0, 1'b1);
    do_reset();
    next_seq = 12'd7;
    tx_log.delete();
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    chk("t7_tx_len", 128'(tx_log.size()), 128'(1));
    if (tx_log.size() > 0) chk("t7_tx_seq", 128'(tx_log[0]), 128'(7));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
